stopwatch_display: RTL and testbench

Downstream display stage for the stopwatch: consumes the binary `minutes`/`seconds` count and the 2-bit `status` from the stopwatch core. It converts both fields to BCD with a sequential double-dabble engine and time-multiplexes them onto a 4-digit common-anode 7-segment display as MM.SS. The whole display blinks while the stopwatch is paused.

---
 rtl/stopwatch_display.sv | 167 ++++++++++++++++
 tb/tb_stopwatch_display.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/stopwatch_display.sv
// Display stage for the stopwatch: double-dabble conversion of MM:SS and
// multiplexed drive of a 4-digit common-anode 7-segment display with pause blink.
module stopwatch_display #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] minutes,
  input  logic [5:0] seconds,
  input  logic [1:0] status,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);
  localparam logic [1:0]    ST_PAUSED    = 2'd2;

  typedef enum logic [1:0] {
    CONV_IDLE,
    CONV_RUN,
    CONV_UPDATE
  } conv_state_t;

  conv_state_t conv_state;

  logic [6:0]       min_clamped;
  logic [5:0]       sec_clamped;
  logic [12:0]      captured;
  logic [6:0]       min_bin;
  logic [6:0]       sec_bin;
  logic [7:0]       min_bcd;
  logic [7:0]       sec_bcd;
  logic [2:0]       iter;
  logic [3:0][3:0]  digits;

  logic [RW-1:0]    refresh_cnt;
  logic [1:0]       scan_idx;
  logic             scan_wrap;
  logic [BW-1:0]    blink_cnt;
  logic             phase_on;

  logic [3:0]       cur_digit;
  logic [6:0]       seg_next;

  // One double-dabble step on a two-nibble accumulator; inputs never exceed 99.
  function automatic logic [7:0] dabble_step(input logic [7:0] bcd, input logic bit_in);
    logic [7:0] adj;
    adj = bcd;
    if (bcd[3:0] >= 4'd5) adj = adj + 8'h03;
    if (bcd[7:4] >= 4'd5) adj = adj + 8'h30;
    return (adj << 1) | {7'b0, bit_in};
  endfunction

  always_comb begin
    min_clamped = (minutes > 7'd99) ? 7'd99 : minutes;
    sec_clamped = (seconds > 6'd59) ? 6'd59 : seconds;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_state <= CONV_IDLE;
      captured   <= '0;
      min_bin    <= '0;
      sec_bin    <= '0;
      min_bcd    <= '0;
      sec_bcd    <= '0;
      iter       <= '0;
      digits     <= '0;
    end else begin
      case (conv_state)
        CONV_IDLE: begin
          if ({min_clamped, sec_clamped} != captured) begin
            captured   <= {min_clamped, sec_clamped};
            min_bin    <= min_clamped;
            sec_bin    <= {1'b0, sec_clamped};
            min_bcd    <= '0;
            sec_bcd    <= '0;
            iter       <= '0;
            conv_state <= CONV_RUN;
          end
        end
        CONV_RUN: begin
          min_bcd <= dabble_step(min_bcd, min_bin[6]);
          sec_bcd <= dabble_step(sec_bcd, sec_bin[6]);
          min_bin <= {min_bin[5:0], 1'b0};
          sec_bin <= {sec_bin[5:0], 1'b0};
          iter    <= iter + 3'd1;
          if (iter == 3'd6) conv_state <= CONV_UPDATE;
        end
        CONV_UPDATE: begin
          digits     <= {min_bcd[7:4], min_bcd[3:0], sec_bcd[7:4], sec_bcd[3:0]};
          conv_state <= CONV_IDLE;
        end
        default: conv_state <= CONV_IDLE;
      endcase
    end
  end

  assign scan_wrap = (refresh_cnt == REFRESH_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      scan_idx    <= '0;
    end else if (scan_wrap) begin
      refresh_cnt <= '0;
      scan_idx    <= scan_idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // Outside PAUSED the blink state is pinned so a new pause starts visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      phase_on  <= 1'b1;
    end else if (status != ST_PAUSED) begin
      blink_cnt <= '0;
      phase_on  <= 1'b1;
    end else if (scan_wrap) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        phase_on  <= ~phase_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign cur_digit = digits[scan_idx];

  always_comb begin
    seg_next = 7'b1111111;
    case (cur_digit)
      4'd0: seg_next = 7'b1000000;
      4'd1: seg_next = 7'b1111001;
      4'd2: seg_next = 7'b0100100;
      4'd3: seg_next = 7'b0110000;
      4'd4: seg_next = 7'b0011001;
      4'd5: seg_next = 7'b0010010;
      4'd6: seg_next = 7'b0000010;
      4'd7: seg_next = 7'b1111000;
      4'd8: seg_next = 7'b0000000;
      4'd9: seg_next = 7'b0010000;
      default: seg_next = 7'b1111111;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else begin
      an  <= phase_on ? ~(4'b0001 << scan_idx) : 4'b1111;
      seg <= seg_next;
      dp  <= !(phase_on && (scan_idx == 2'd2));
    end
  end

endmodule

// File: tb/tb_stopwatch_display.sv
// Randomised bench for stopwatch_display against an arithmetic reference of
// conversion latency, scan position and pause blink.
module tb_stopwatch_display;

  localparam int RD = 4;
  localparam int BD = 2;
  localparam logic [6:0] SEG_LUT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] minutes = '0;
  logic [5:0] seconds = '0;
  logic [1:0] status = '0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks = 0;
  int failures = 0;

  // Reference state: cycles since reset, conversion busy countdown, values.
  int t, busy, cap_min, cap_sec, d_min, d_sec, steps;
  bit ph_on;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp;

  stopwatch_display #(.REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .minutes (minutes),
    .seconds (seconds),
    .status  (status),
    .an      (an),
    .seg     (seg),
    .dp      (dp)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
    end
  endtask

  task automatic model_reset();
    t = 0; busy = 0; cap_min = 0; cap_sec = 0; d_min = 0; d_sec = 0; steps = 0;
    ph_on = 1'b1;
    exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
  endtask

  // Advances the reference across one rising edge using the pre-edge inputs.
  task automatic model_step();
    int idx, dig, cm, cs;
    idx = (t / RD) % 4;
    case (idx)
      0: dig = d_sec % 10;
      1: dig = d_sec / 10;
      2: dig = d_min % 10;
      default: dig = d_min / 10;
    endcase
    exp_seg = SEG_LUT[dig];
    exp_an  = ph_on ? ~(4'(1) << idx) : 4'hF;
    exp_dp  = (ph_on && idx == 2) ? 1'b0 : 1'b1;

    cm = (int'(minutes) > 99) ? 99 : int'(minutes);
    cs = (int'(seconds) > 59) ? 59 : int'(seconds);
    if (busy == 0) begin
      if (cm != cap_min || cs != cap_sec) begin
        cap_min = cm;
        cap_sec = cs;
        busy = 8;
      end
    end else begin
      busy--;
      if (busy == 0) begin
        d_min = cap_min;
        d_sec = cap_sec;
      end
    end

    if (status == 2'd2) begin
      if (t % RD == RD - 1) steps++;
    end else begin
      steps = 0;
    end
    ph_on = ((steps / BD) % 2) == 0;
    t++;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    checkOutput("an", an, exp_an);
    checkOutput("seg", seg, exp_seg);
    checkOutput("dp", dp, exp_dp);
  endtask

  task automatic applyStimulus(input int m, input int s, input int st, input int n);
    minutes = 7'(m);
    seconds = 6'(s);
    status  = 2'(st);
    repeat (n) cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_an"}, an, 4'hF);
    checkOutput({tag, "_seg"}, seg, 7'h7F);
    checkOutput({tag, "_dp"}, dp, 1);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;

    applyStimulus(12, 34, 1, 8 + 2 * 4 * RD);
    applyStimulus(127, 63, 1, 40);
    applyStimulus(99, 59, 1, 20);

    // Change seconds while the conversion of 5 is still in flight.
    applyStimulus(0, 5, 1, 3);
    applyStimulus(0, 6, 1, 30);

    applyStimulus(0, 6, 2, 40);
    applyStimulus(0, 6, 2, 10);
    applyStimulus(0, 6, 1, 12);
    applyStimulus(0, 6, 3, 8);

    // Asynchronous reset between edges, in the middle of a conversion.
    applyStimulus(45, 17, 1, 4);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    check_reset_outputs("rst_hold");
    rst_n = 1'b1;
    applyStimulus(45, 17, 1, 24);

    repeat (40) begin
      int st_pick;
      st_pick = $urandom_range(0, 5);
      applyStimulus($urandom_range(0, 127), $urandom_range(0, 63),
                    (st_pick > 3) ? 2 : st_pick, $urandom_range(1, 24));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
